rotate_sequencer: RTL and testbench
===================================

# rotate_sequencer

Multi-cycle controller that performs variable-amount circular rotations, left or right, on an N-bit word. It sequences a single rotate-by-2^k datapath through log2(N) conditional stages and uses a valid/ready handshake on both sides. Requesters that need runtime-selected rotate amounts use this block instead of fixed-S rotator instances. It sits between a request producer and a result consumer.

## Interface
- N, default 8: data width in bits, N >= 2.
- SW, default $clog2(N): rotate-amount width (derived, not overridden).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- in_data  in  N  word to rotate.
- in_amt  in  SW  rotate amount; the effective rotation is in_amt mod N.
- in_dir  in  1  rotation direction: 0 = left (toward MSB), 1 = right (toward LSB).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  N  rotated word.

## Operation
- Reset values: state IDLE, out_valid 0, out_data 0, internal amount/direction/stage counter 0.
- in_ready is driven combinationally as (state == IDLE) && !rst.
- The FSM has three states: IDLE, ROT and DONE.
- IDLE: on in_valid && in_ready, the block does three things:
  - latches in_data into the working register, and latches in_amt and in_dir;
  - clears stage counter k;
  - moves to ROT.
- ROT, one stage per cycle:
  - if amt[k] = 1, the working register is rotated by 2^k in the latched direction; otherwise it is unchanged;
  - k increments;
  - after the stage with k = SW-1, the FSM goes to DONE.
- Rotation is true circular: bits shifted out of one end re-enter at the other end.
- For N not a power of two, amounts >= N still compose correctly. For example, N=6, amt=7 is equivalent to rotating by 1.
- DONE: out_valid = 1 and out_data = working register.
  - On out_ready, the FSM returns to IDLE and out_valid drops on the next edge.
  - While out_ready = 0, out_data and out_valid hold stable.
- Only one request is in flight at a time. No new request is accepted in ROT or DONE, because in_ready = 0.
- Inputs in_data, in_amt and in_dir are ignored when no handshake takes place.
- rst asserted in any state, including mid-ROT or DONE with the result unconsumed:
  - the in-flight operation is discarded;
  - all reset values are applied at that edge;
  - no out_valid pulse follows.

## Timing
- Acceptance happens at edge t, and out_valid is first observed high after edge t+SW. With N=8, that is 3 rotate cycles.
- A result is consumed at edge u when out_valid && out_ready. in_ready is high in the cycle after u.
- Maximum throughput is one request per SW+2 cycles with out_ready held high.
- in_ready does not depend combinationally on out_ready or in_valid.

## Configuration
- ROTATE_SEQUENCER_EARLY_EXIT_EN undefined: fixed latency of SW cycles for every amount, including amt = 0.
- ROTATE_SEQUENCER_EARLY_EXIT_EN defined:
  - In ROT, when amt[SW-1:k] is all zeros, the FSM goes straight to DONE without spending further cycles.
  - amt = 0 goes from IDLE directly to DONE at the acceptance edge, so out_valid is high after edge t.
  - In general, out_valid is high after edge t + (index of highest set bit of amt + 1).
  - Results are identical with and without the macro; only latency differs.

## Test plan
- N=8, in_data=10110101, amt=3, dir=0 -> out_data=10101101, out_valid high exactly 3 cycles after acceptance.
- Same data, amt=3, dir=1 -> out_data=10110110; amt=7, dir=1, data=00000001 -> 00000010.
- amt=0, data=01100110 -> out_data=01100110; latency 3 without the macro, out_valid right after acceptance with it; amt=1 with the macro -> latency 1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_data and out_valid stable, in_ready=0 throughout; raise out_ready -> in_ready=1 in the following cycle.
- Assert rst for one cycle during the second ROT cycle -> out_valid stays 0, out_data=0, in_ready=1 after release; the next request (11110000, amt=3, left) -> 10000111.
- Back-to-back requests with in_valid held high and out_ready=1 -> each result is correct and in_ready rises exactly one cycle after each result handshake.

Source files
------------

// File: rtl/rotate_sequencer.sv
// Multi-cycle circular rotator: one conditional rotate-by-2^k stage per cycle, valid/ready on both sides.
// Optional macro ROTATE_SEQUENCER_EARLY_EXIT_EN finishes as soon as no higher amount bits remain set.
module rotate_sequencer #(
   parameter  int unsigned N  = 8,
   localparam int unsigned SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic [SW-1:0] in_amt,
   input  logic          in_dir,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data
);

   localparam logic [SW-1:0] K_LAST = SW'(SW - 1);

   typedef enum logic [1:0] {
      IDLE,
      ROT,
      DONE
   } state_t;

   state_t        state, state_nxt;
   logic [N-1:0]  work, work_nxt;
   logic [SW-1:0] amt, amt_nxt;
   logic          dir, dir_nxt;
   logic [SW-1:0] k, k_nxt;
   logic          out_valid_nxt;
   logic [N-1:0]  out_data_nxt;

   int unsigned   sh;
   logic [N-1:0]  rot_l, rot_r, stage_out;
   logic          last_stage;

   assign in_ready = (state == IDLE) && !rst;

   // Rotate by 2^k; 2^k < N always holds because SW = ceil(log2(N)).
   assign sh        = 32'(1) << k;
   assign rot_l     = (work << sh) | (work >> (N - sh));
   assign rot_r     = (work >> sh) | (work << (N - sh));
   assign stage_out = dir ? rot_r : rot_l;

   // amt shifts right each stage, so amt[0] is always the bit for the current k.
`ifdef ROTATE_SEQUENCER_EARLY_EXIT_EN
   assign last_stage = (k == K_LAST) || ((amt >> 1) == '0);
`else
   assign last_stage = (k == K_LAST);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         work      <= '0;
         amt       <= '0;
         dir       <= 1'b0;
         k         <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         state     <= state_nxt;
         work      <= work_nxt;
         amt       <= amt_nxt;
         dir       <= dir_nxt;
         k         <= k_nxt;
         out_valid <= out_valid_nxt;
         out_data  <= out_data_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      work_nxt      = work;
      amt_nxt       = amt;
      dir_nxt       = dir;
      k_nxt         = k;
      out_valid_nxt = out_valid;
      out_data_nxt  = out_data;
      unique case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               work_nxt  = in_data;
               amt_nxt   = in_amt;
               dir_nxt   = in_dir;
               k_nxt     = '0;
               state_nxt = ROT;
`ifdef ROTATE_SEQUENCER_EARLY_EXIT_EN
               if (in_amt == '0) begin
                  state_nxt     = DONE;
                  out_valid_nxt = 1'b1;
                  out_data_nxt  = in_data;
               end
`endif
            end
         end
         ROT: begin
            if (amt[0]) work_nxt = stage_out;
            amt_nxt = amt >> 1;
            k_nxt   = k + SW'(1);
            if (last_stage) begin
               state_nxt     = DONE;
               out_valid_nxt = 1'b1;
               out_data_nxt  = work_nxt;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt     = IDLE;
               out_valid_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed self-checking bench for rotate_sequencer (N=8); latency expectations follow ROTATE_SEQUENCER_EARLY_EXIT_EN.
module tb_rotate_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_amt;
   logic       in_dir;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;

   int checks = 0;
   int errors = 0;

   rotate_sequencer #(.N(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_dir    (in_dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected edges from acceptance to first out_valid.
   function automatic int exp_lat(input logic [2:0] a);
`ifdef ROTATE_SEQUENCER_EARLY_EXIT_EN
      int l;
      l = 0;
      for (int b = 0; b < 3; b++) if (a[b]) l = b + 1;
      return l;
`else
      return (a == 3'd0) ? 3 : 3;
`endif
   endfunction

   // Present one request, wait for its result and check data and latency; does not consume it.
   task automatic run_req(input string name, input logic [7:0] d, input logic [2:0] a,
                          input logic dr, input logic [7:0] exp_d);
      int lat;
      in_data  = d;
      in_amt   = a;
      in_dir   = dr;
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
      end
      tick();
      in_valid = 1'b0;
      in_data  = ~d;
      in_amt   = ~a;
      in_dir   = ~dr;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != exp_lat(a)) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat(a));
      end
      checks++;
      if (out_data !== exp_d) begin
         errors++;
         $display("FAIL %s out_data: got %b want %b", name, out_data, exp_d);
      end
   endtask

   task automatic consume(input string name);
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s after consume: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: out_valid=%b out_data=%b in_ready=%b want 0/00000000/0",
                  out_valid, out_data, in_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_rotate();
      out_ready = 1'b1;
      run_req("left3",  8'b10110101, 3'd3, 1'b0, 8'b10101101);
      consume("left3");
      run_req("right3", 8'b10110101, 3'd3, 1'b1, 8'b10110110);
      consume("right3");
      run_req("right7", 8'b00000001, 3'd7, 1'b1, 8'b00000010);
      consume("right7");
      run_req("amt0",   8'b01100110, 3'd0, 1'b0, 8'b01100110);
      consume("amt0");
      run_req("left1",  8'b10000001, 3'd1, 1'b0, 8'b00000011);
      consume("left1");
      run_req("right4", 8'b11001010, 3'd4, 1'b1, 8'b10101100);
      consume("right4");
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      run_req("bp", 8'b00001111, 3'd2, 1'b0, 8'b00111100);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'b00111100 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: out_valid=%b out_data=%b in_ready=%b want 1/00111100/0",
                     i, out_valid, out_data, in_ready);
         end
      end
      consume("bp");
   endtask

   task automatic test_reset_mid_rot();
      out_ready = 1'b1;
      in_data   = 8'b10110101;
      in_amt    = 3'd7;
      in_dir    = 1'b0;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_rot: out_valid=%b out_data=%b in_ready=%b want 0/00000000/1",
                  out_valid, out_data, in_ready);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_pulse cycle %0d: out_valid=%b want 0", i, out_valid);
         end
      end
      run_req("post_rst", 8'b11110000, 3'd3, 1'b0, 8'b10000111);
      consume("post_rst");
   endtask

   task automatic test_back_to_back();
      logic [7:0] vd [3];
      logic [2:0] va [3];
      logic       vr [3];
      logic [7:0] ve [3];
      int lat;
      vd[0] = 8'b10110101; va[0] = 3'd5; vr[0] = 1'b0; ve[0] = 8'b10110110;
      vd[1] = 8'b00110001; va[1] = 3'd6; vr[1] = 1'b1; ve[1] = 8'b11000100;
      vd[2] = 8'b11100000; va[2] = 3'd2; vr[2] = 1'b1; ve[2] = 8'b00111000;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = vd[i];
         in_amt  = va[i];
         in_dir  = vr[i];
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b%0d in_ready: got %b want 1", i, in_ready);
         end
         tick();
         in_data = 8'h5a;
         in_amt  = 3'd7;
         in_dir  = ~vr[i];
         if (i == 2) in_valid = 1'b0;
         lat = 0;
         while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
         end
         checks++;
         if (lat != exp_lat(va[i]) || out_data !== ve[i]) begin
            errors++;
            $display("FAIL b2b%0d result: lat=%0d data=%b want lat=%0d data=%b",
                     i, lat, out_data, exp_lat(va[i]), ve[i]);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b%0d in_ready during DONE: got %b want 0", i, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b%0d after handshake: out_valid=%b in_ready=%b want 0/1",
                     i, out_valid, in_ready);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_amt    = 3'd0;
      in_dir    = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_rotate();
      test_backpressure();
      test_reset_mid_rot();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
